// File: rtl/pr_region_update_ctrl_pkg.sv
// Shared encodings for the region update controller: request opcodes,
// response status codes, FSM state encoding and the blank module ID that is
// written to the lookup table when a region is released.
package pr_region_update_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_RELEASE = 2'd1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_DENIED     = 2'd1,
    ST_BAD_REGION = 2'd2,
    ST_BAD_OP     = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_HOLD  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  localparam logic [3:0] RMID_BLANK = 4'd0;

endpackage

// File: rtl/pr_region_update_ctrl_region_owner_table.sv
// Per-region ownership storage: one owned bit plus the owner tenant ID.
// Ports:
//   clk, resetn          clock, synchronous active-low reset (clears all ownership)
//   lk_rrid              lookup region
//   lk_owned, lk_owner   lookup result (0/0 for regions outside the table)
//   wr_en                commit a claim or clear for wr_rrid
//   wr_rrid              region to write
//   wr_claim             1 = mark owned by wr_tenant, 0 = mark unowned
//   wr_tenant            tenant recorded on a claim
module region_owner_table #(
  parameter int NUM_REGIONS = 3,
  parameter int TID_W       = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       lk_rrid,
  output logic             lk_owned,
  output logic [TID_W-1:0] lk_owner,
  input  logic             wr_en,
  input  logic [3:0]       wr_rrid,
  input  logic             wr_claim,
  input  logic [TID_W-1:0] wr_tenant
);

  logic [NUM_REGIONS-1:0] owned_q;
  logic [TID_W-1:0]       owner_q [NUM_REGIONS];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owned_q <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) owner_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (wr_en && (wr_rrid == 4'(i))) begin
          owned_q[i] <= wr_claim;
          owner_q[i] <= wr_claim ? wr_tenant : '0;
        end
      end
    end
  end

  // Compare-based select keeps out-of-range region IDs from indexing past
  // the table; they simply read back as unowned.
  always_comb begin
    lk_owned = 1'b0;
    lk_owner = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (lk_rrid == 4'(i)) begin
        lk_owned = owned_q[i];
        lk_owner = owner_q[i];
      end
    end
  end

endmodule

// File: rtl/pr_region_update_ctrl.sv
// Tenant-facing front end of the region->module lookup table. Accepts one
// reconfiguration request at a time, enforces region ownership, drives the
// table's update strobe with rrid/update_val held for the two-cycle write
// path, and returns a status per request.
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_op/tenant/rrid/rmid        request fields
//   update, rrid, update_val       table write interface (registered)
//   resp_valid, resp_status        one-cycle response strobe and status
//   violation_cnt                  saturating count of cross-tenant attempts
//   busy                           high whenever the FSM is not in IDLE
//
// state   | meaning
// IDLE    | ready for a request; capture fields on req_valid
// CHECK   | range/op/ownership check, ownership change commits here
// ISSUE   | update strobe high with new rrid/update_val
// HOLD    | HOLD_CYCLES cycles keeping rrid/update_val frozen
// RESP    | resp_valid with status
module pr_region_update_ctrl
  import pr_region_update_ctrl_pkg::*;
#(
  parameter int NUM_REGIONS = 3,
  parameter int TID_W       = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [TID_W-1:0] req_tenant,
  input  logic [3:0]       req_rrid,
  input  logic [3:0]       req_rmid,
  output logic             update,
  output logic [3:0]       rrid,
  output logic [3:0]       update_val,
  output logic             resp_valid,
  output logic [1:0]       resp_status,
  output logic [CNT_W-1:0] violation_cnt,
  output logic             busy
);

  localparam int         HCW           = $clog2(HOLD_CYCLES + 1);
  localparam logic [4:0] NUM_REGIONS_L = 5'(NUM_REGIONS);

  state_e           state_q, state_d;
  logic [1:0]       cap_op_q;
  logic [TID_W-1:0] cap_tenant_q;
  logic [3:0]       cap_rrid_q, cap_rmid_q;
  logic [1:0]       status_q, status_d;
  logic [HCW-1:0]   hold_cnt_q;
  logic [CNT_W-1:0] viol_q;
  logic             update_q, resp_valid_q, busy_q;
  logic [3:0]       rrid_q, update_val_q;
  logic [1:0]       resp_status_q;

  logic             lk_owned, same_owner;
  logic [TID_W-1:0] lk_owner;
  logic             tbl_we, tbl_claim, viol_inc;

  region_owner_table #(
    .NUM_REGIONS(NUM_REGIONS),
    .TID_W      (TID_W)
  ) u_owner (
    .clk      (clk),
    .resetn   (resetn),
    .lk_rrid  (cap_rrid_q),
    .lk_owned (lk_owned),
    .lk_owner (lk_owner),
    .wr_en    (tbl_we),
    .wr_rrid  (cap_rrid_q),
    .wr_claim (tbl_claim),
    .wr_tenant(cap_tenant_q)
  );

  assign same_owner = lk_owned && (lk_owner == cap_tenant_q);

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    tbl_we    = 1'b0;
    tbl_claim = 1'b0;
    viol_inc  = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) state_d = S_CHECK;
      S_CHECK: begin
        // Region range is judged before the opcode.
        if ({1'b0, cap_rrid_q} >= NUM_REGIONS_L) begin
          status_d = ST_BAD_REGION;
        end else if (cap_op_q == OP_LOAD) begin
          if (!lk_owned) begin
            tbl_we    = 1'b1;
            tbl_claim = 1'b1;
            status_d  = ST_OK;
          end else if (same_owner) begin
            status_d = ST_OK;
          end else begin
            status_d = ST_DENIED;
            viol_inc = 1'b1;
          end
        end else if (cap_op_q == OP_RELEASE) begin
          if (same_owner) begin
            tbl_we   = 1'b1;
            status_d = ST_OK;
          end else begin
            // Releasing an unowned region is refused but is not an attack.
            status_d = ST_DENIED;
            viol_inc = lk_owned;
          end
        end else begin
          status_d = ST_BAD_OP;
        end
        state_d = (status_d == ST_OK) ? S_ISSUE : S_RESP;
      end
      S_ISSUE: state_d = S_HOLD;
      S_HOLD:  if (hold_cnt_q == '0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cap_op_q      <= '0;
      cap_tenant_q  <= '0;
      cap_rrid_q    <= '0;
      cap_rmid_q    <= '0;
      status_q      <= '0;
      hold_cnt_q    <= '0;
      viol_q        <= '0;
      update_q      <= 1'b0;
      rrid_q        <= '0;
      update_val_q  <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;

      if (state_q == S_IDLE && req_valid) begin
        cap_op_q     <= req_op;
        cap_tenant_q <= req_tenant;
        cap_rrid_q   <= req_rrid;
        cap_rmid_q   <= req_rmid;
      end

      // Down-counter: loaded as HOLD is entered, HOLD exits at terminal count.
      if (state_q == S_ISSUE) begin
        hold_cnt_q <= HCW'(HOLD_CYCLES - 1);
      end else if (state_q == S_HOLD && hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - HCW'(1);
      end

      if (viol_inc && viol_q != '1) viol_q <= viol_q + CNT_W'(1);

      // Outputs are registered from the next state so they line up with it.
      update_q <= (state_d == S_ISSUE);
      if (state_q == S_CHECK && state_d == S_ISSUE) begin
        rrid_q       <= cap_rrid_q;
        update_val_q <= (cap_op_q == OP_RELEASE) ? RMID_BLANK : cap_rmid_q;
      end
      resp_valid_q  <= (state_d == S_RESP);
      resp_status_q <= (state_d == S_RESP) ? status_d : 2'd0;
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign update        = update_q;
  assign rrid          = rrid_q;
  assign update_val    = update_val_q;
  assign resp_valid    = resp_valid_q;
  assign resp_status   = resp_status_q;
  assign violation_cnt = viol_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pr_region_update_ctrl.sv
module tb_pr_region_update_ctrl;
  localparam int NR = 3, TW = 2, H = 2, CW = 8;
  localparam int NCYC = 4 + H;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [TW-1:0] req_tenant = '0;
  logic [3:0]    req_rrid = '0, req_rmid = '0;
  logic          update;
  logic [3:0]    rrid, update_val;
  logic          resp_valid;
  logic [1:0]    resp_status;
  logic [CW-1:0] violation_cnt;
  logic          busy;

  pr_region_update_ctrl #(
    .NUM_REGIONS(NR), .TID_W(TW), .HOLD_CYCLES(H), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_tenant(req_tenant), .req_rrid(req_rrid), .req_rmid(req_rmid),
    .update(update), .rrid(rrid), .update_val(update_val), .resp_valid(resp_valid),
    .resp_status(resp_status), .violation_cnt(violation_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  // Reference model: ownership arrays, violation count, last written values.
  bit         m_owned [16];
  int         m_owner [16];
  int         m_viol;
  logic [3:0] m_rrid, m_val;
  logic [1:0] last_status;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_owned[i] = 1'b0;
      m_owner[i] = 0;
    end
    m_viol = 0;
    m_rrid = '0;
    m_val  = '0;
  endtask

  task automatic do_req(input int op, input int ten, input int rr, input int rm, input bit noise);
    int st, rc, guard, bad_k;
    bit ok, hold_bad;
    logic [7:0] upd_v, rsp_v, bsy_v, rdy_v, upd_e, rsp_e, bsy_e, rdy_e;
    logic [1:0] st_seen;
    logic [3:0] exp_rrid, exp_val, bad_rrid, bad_val, want_r, want_v;

    if (rr >= NR) st = 2;
    else if (op > 1) st = 3;
    else if (op == 0) begin
      if (!m_owned[rr]) begin m_owned[rr] = 1'b1; m_owner[rr] = ten; st = 0; end
      else if (m_owner[rr] == ten) st = 0;
      else begin st = 1; if (m_viol < 255) m_viol++; end
    end else begin
      if (m_owned[rr] && m_owner[rr] == ten) begin m_owned[rr] = 1'b0; st = 0; end
      else begin st = 1; if (m_owned[rr] && m_viol < 255) m_viol++; end
    end
    ok       = (st == 0);
    rc       = ok ? 3 + H : 2;
    exp_rrid = ok ? 4'(rr) : m_rrid;
    exp_val  = ok ? ((op == 1) ? 4'd0 : 4'(rm)) : m_val;

    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    n_total++;
    if (req_ready !== 1'b1) begin
      $display("FAIL ready_timeout: req_ready=%b want 1", req_ready);
      return;
    end
    n_pass++;
    req_valid = 1'b1; req_op = 2'(op); req_tenant = TW'(ten);
    req_rrid = 4'(rr); req_rmid = 4'(rm);
    @(posedge clk);
    #1 req_valid = 1'b0;

    upd_v = '0; rsp_v = '0; bsy_v = '0; rdy_v = '0; st_seen = '0;
    hold_bad = 1'b0; bad_k = 0; bad_rrid = '0; bad_val = '0;
    for (int k = 1; k <= NCYC; k++) begin
      @(negedge clk);
      upd_v[k] = update; rsp_v[k] = resp_valid; bsy_v[k] = busy; rdy_v[k] = req_ready;
      if (k == rc) st_seen = resp_status;
      want_r = (k >= 2) ? exp_rrid : m_rrid;
      want_v = (k >= 2) ? exp_val : m_val;
      if (!hold_bad && (rrid !== want_r || update_val !== want_v)) begin
        hold_bad = 1'b1; bad_k = k; bad_rrid = rrid; bad_val = update_val;
      end
      if (noise && k < rc) begin
        req_valid = 1'b1; req_op = 2'($urandom); req_tenant = TW'($urandom);
        req_rrid = 4'($urandom); req_rmid = 4'($urandom);
      end else req_valid = 1'b0;
    end

    upd_e = ok ? 8'b0000_0100 : 8'b0;
    rsp_e = 8'(1 << rc);
    bsy_e = 8'((1 << (rc + 1)) - 2);
    rdy_e = ~bsy_e & 8'h7E;

    n_total++;
    if (upd_v !== upd_e) $display("FAIL update_pattern op=%0d rr=%0d: got %b want %b", op, rr, upd_v, upd_e);
    else n_pass++;
    n_total++;
    if (rsp_v !== rsp_e) $display("FAIL resp_pattern op=%0d rr=%0d: got %b want %b", op, rr, rsp_v, rsp_e);
    else n_pass++;
    n_total++;
    if (bsy_v !== bsy_e) $display("FAIL busy_pattern op=%0d rr=%0d: got %b want %b", op, rr, bsy_v, bsy_e);
    else n_pass++;
    n_total++;
    if (rdy_v !== rdy_e) $display("FAIL ready_pattern op=%0d rr=%0d: got %b want %b", op, rr, rdy_v, rdy_e);
    else n_pass++;
    n_total++;
    if (st_seen !== 2'(st)) $display("FAIL resp_status op=%0d rr=%0d t=%0d: got %0d want %0d", op, rr, ten, st_seen, st);
    else n_pass++;
    n_total++;
    if (hold_bad) $display("FAIL rrid_val_hold cycle=%0d: got rrid=%0d val=%0d want rrid=%0d val=%0d",
                           bad_k, bad_rrid, bad_val, (bad_k >= 2) ? exp_rrid : m_rrid, (bad_k >= 2) ? exp_val : m_val);
    else n_pass++;
    n_total++;
    if (violation_cnt !== CW'(m_viol)) $display("FAIL violation_cnt: got %0d want %0d", violation_cnt, m_viol);
    else n_pass++;

    m_rrid = exp_rrid;
    m_val  = exp_val;
    last_status = st_seen;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({update, rrid, update_val, resp_valid, resp_status, violation_cnt, busy} !== '0)
      $display("FAIL reset_outputs: got upd=%b rrid=%0d val=%0d rv=%b rs=%0d cnt=%0d busy=%b want all 0",
               update, rrid, update_val, resp_valid, resp_status, violation_cnt, busy);
    else n_pass++;
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    n_total++;
    if ({req_ready, busy} !== 2'b10) $display("FAIL reset_idle: got ready=%b busy=%b want ready=1 busy=0", req_ready, busy);
    else n_pass++;
  endtask

  task automatic test_plan();
    do_req(0, 1, 1, 5, 1'b0);
    n_total++;
    if (last_status !== 2'd0) $display("FAIL plan_load_ok: got %0d want 0", last_status);
    else n_pass++;
    do_req(0, 2, 1, 7, 1'b0);
    n_total++;
    if (violation_cnt !== 8'd1) $display("FAIL plan_cross_count: got %0d want 1", violation_cnt);
    else n_pass++;
    do_req(1, 1, 1, 9, 1'b0);
    do_req(0, 2, 1, 7, 1'b0);
    n_total++;
    if (update_val !== 4'd7) $display("FAIL plan_reload_val: got %0d want 7", update_val);
    else n_pass++;
  endtask

  task automatic test_bad_inputs();
    do_req(0, 0, 3, 4, 1'b0);
    do_req(2, 0, 0, 1, 1'b0);
    do_req(3, 0, 5, 1, 1'b0);
    do_req(1, 3, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      do_req($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
             $urandom_range(0, 15), 1'($urandom));
  endtask

  task automatic test_saturation();
    int o;
    if (!m_owned[0]) do_req(0, 0, 0, 1, 1'b0);
    o = m_owner[0];
    for (int i = 0; i < 300; i++) do_req(0, (o + 1) % 4, 0, $urandom_range(0, 15), 1'b0);
    n_total++;
    if (violation_cnt !== 8'hFF) $display("FAIL saturation: got %0d want 255", violation_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    int t, guard;
    bit bad;
    t = m_owned[2] ? m_owner[2] : 0;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_op = 2'd0; req_tenant = TW'(t); req_rrid = 4'd2; req_rmid = 4'd9;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (update !== 1'b1) $display("FAIL midhold_issue: got update=%b want 1", update);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if ({update, rrid, update_val, resp_valid, resp_status, violation_cnt, busy} !== '0) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL midhold_reset: got rv=%b cnt=%0d busy=%b rrid=%0d want all 0",
                      resp_valid, violation_cnt, busy, rrid);
    else n_pass++;
    resetn = 1'b1;
    model_reset();
    do_req(0, (t + 1) % 4, 2, 3, 1'b0);
    n_total++;
    if (last_status !== 2'd0) $display("FAIL midhold_ownership_cleared: got %0d want 0", last_status);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_plan();
    test_bad_inputs();
    test_random();
    test_saturation();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pr_region_update_ctrl.md
Name: pr_region_update_ctrl

Overview:
- Upstream stage of the region→module lookup table. Accepts per-tenant reconfiguration requests over a valid/ready handshake.
- Enforces region ownership so a tenant can only load or clear regions it owns.
- Drives the table's update interface (update, rrid, update_val), holding values stable long enough for the table's two-cycle write path.
- Returns a status per request and counts cross-tenant violations.

Parameters:
- NUM_REGIONS, 3, number of valid reconfigurable regions (legal rrid 0..NUM_REGIONS-1, max 16)
- TID_W, 2, tenant ID width
- HOLD_CYCLES, 2, cycles rrid/update_val stay frozen after the update pulse (minimum 2)
- CNT_W, 8, violation counter width

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  0=LOAD, 1=RELEASE, 2/3 illegal
- req_tenant  in  TID_W  requesting tenant
- req_rrid  in  4  target region
- req_rmid  in  4  module ID to load (ignored for RELEASE)
- update  out  1  one-cycle write strobe to table
- rrid  out  4  region to write
- update_val  out  4  module ID to write
- resp_valid  out  1  one-cycle response strobe
- resp_status  out  2  0=OK, 1=DENIED, 2=BAD_REGION, 3=BAD_OP
- violation_cnt  out  CNT_W  saturating count of cross-tenant attempts
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (resetn sampled on posedge clk).
- Reset values: all outputs 0. Ownership table all unowned. FSM in IDLE.
- Reset mid-operation: aborts at the next edge. The pending request is dropped with no response; ownership is cleared and the counter is zeroed.
- Registers: all outputs are registered; no combinational path from inputs to outputs except that req_ready is derived from state only.
- Ownership table: per region, an owned bit plus an owner tenant ID.
- States: IDLE, CHECK, ISSUE, HOLD, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture op/tenant/rrid/rmid and go to CHECK.
  - req_ready=0 in all other states.
- CHECK (1 cycle):
  - rrid ≥ NUM_REGIONS → status BAD_REGION. Checked first, before op.
  - op 2/3 → BAD_OP.
  - LOAD, region unowned → claim it for the tenant; OK.
  - LOAD, owned by the same tenant → OK.
  - LOAD, owned by another tenant → DENIED; violation_cnt+1.
  - RELEASE, owned by the same tenant → clear ownership; OK; write value is 0.
  - RELEASE, unowned → DENIED; no count.
  - RELEASE, owned by another tenant → DENIED; violation_cnt+1.
  - Next state: OK → ISSUE; otherwise → RESP.
  - Ownership changes commit at the end of CHECK.
- ISSUE (1 cycle):
  - update=1.
  - rrid/update_val take the new values on entry to ISSUE.
  - Go to HOLD.
- HOLD (HOLD_CYCLES cycles): update=0; rrid/update_val unchanged; then RESP.
- RESP (1 cycle): resp_valid=1 with resp_status; then IDLE.
- Latency:
  - OK path: handshake at edge 0; update high in cycle 2; resp_valid in cycle 3+HOLD_CYCLES.
  - Reject path: resp_valid in cycle 2.
  - Next request can be accepted the cycle after RESP.
- Output persistence: rrid/update_val keep their last value at all times outside ISSUE entry, never returning to 0 between requests.
- update is never high for two consecutive cycles.
- violation_cnt saturates at all-ones; it is never cleared except by reset.
- Simultaneous events: only one request in flight. req_valid while busy is ignored, and the requester must hold it until req_ready.

Decomposition:
- Shared package: op encodings (OP_LOAD, OP_RELEASE), status encodings, FSM state encoding, and the RMID_BLANK=0 constant.
- One natural sub-module, region_owner_table: ownership storage with a lookup port (rrid → owned, owner) and a write port (claim/clear). The FSM and counter stay in the top module.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles → all outputs 0, req_ready=1 after release.
- Tenant 1 LOAD rrid=1 rmid=5 → update pulse in cycle 2 with rrid=1, update_val=5. Values held through cycle 4, resp_status=0 in cycle 5, busy low in cycle 6.
- Tenant 2 LOAD rrid=1 rmid=7 after the above → no update pulse, resp_status=1 in cycle 2, violation_cnt=1.
- Tenant 1 RELEASE rrid=1 → update_val=0 pulse, OK. A following tenant 2 LOAD rrid=1 rmid=7 → OK, update_val=7.
- Bad inputs:
  - LOAD rrid=3 (NUM_REGIONS=3) → BAD_REGION, no update, count unchanged.
  - op=2 → BAD_OP.
  - RELEASE on an unowned region → DENIED, count unchanged.
- Stress and reset:
  - 300 cross-tenant LOADs → violation_cnt saturates at 255.
  - resetn=0 asserted during HOLD → no resp_valid, outputs 0, ownership cleared (a subsequent LOAD by any tenant succeeds).
